alu_seq: RTL and testbench

//  Registered, handshaked 6502-style ALU: N-bit datapath, internal NVZC flag register, carry chaining across ops.

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked 6502-style ALU with an internal {N,V,Z,C} flag register.
// Define ALU_SEQ_DECIMAL_EN to add nibble-serial BCD ADC/SBC (dec=1) through the DADJ state.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] mem,
  input  logic         tgt,
  input  logic         dec,
  input  logic         flag_wr,
  input  logic [3:0]   flag_din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam logic [3:0] OP_ADC = 4'h0, OP_SBC = 4'h1, OP_AND = 4'h2, OP_ORA = 4'h3,
                         OP_EOR = 4'h4, OP_ASL = 4'h5, OP_LSR = 4'h6, OP_ROL = 4'h7,
                         OP_ROR = 4'h8, OP_CMP = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB;

`ifdef ALU_SEQ_DECIMAL_EN
  typedef enum logic [1:0] {S_IDLE, S_DADJ, S_DONE} state_e;
`else
  typedef enum logic [0:0] {S_IDLE, S_DONE} state_e;
`endif

  state_e state, state_nx, acc_state;
  logic   accept;
  logic   dec_go, dec_done;
  logic [N-1:0] dec_res;
  logic [3:0]   dec_flags;

  assign in_ready  = ((state == S_IDLE) | ((state == S_DONE) & out_ready)) & ~flag_wr;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;

  // Binary datapath: evaluated on the live inputs, registered at the accept edge.
  logic [N-1:0] src, m_eff, bin_res, zn_val;
  logic [N:0]   sum;
  logic [3:0]   bin_flags;
  logic         c_in, v_bin;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    src       = tgt ? mem : a;
    c_in      = flags[0];
    m_eff     = (op == OP_SBC || op == OP_CMP) ? ~mem : mem;
    sum       = {1'b0, a} + {1'b0, m_eff} + {{N{1'b0}}, (op == OP_CMP) ? 1'b1 : c_in};
    v_bin     = (a[N-1] ^ sum[N-1]) & (m_eff[N-1] ^ sum[N-1]);
    bin_res   = a;
    bin_flags = flags;
    case (op)
      OP_ADC, OP_SBC: begin
        bin_res      = sum[N-1:0];
        bin_flags[0] = sum[N];
        bin_flags[2] = v_bin;
      end
      OP_CMP: bin_flags[0] = sum[N];
      OP_AND: bin_res = a & mem;
      OP_ORA: bin_res = a | mem;
      OP_EOR: bin_res = a ^ mem;
      OP_ASL: begin bin_res = {src[N-2:0], 1'b0}; bin_flags[0] = src[N-1]; end
      OP_LSR: begin bin_res = {1'b0, src[N-1:1]}; bin_flags[0] = src[0];   end
      OP_ROL: begin bin_res = {src[N-2:0], c_in}; bin_flags[0] = src[N-1]; end
      OP_ROR: begin bin_res = {c_in, src[N-1:1]}; bin_flags[0] = src[0];   end
      OP_INC: bin_res = src + {{(N-1){1'b0}}, 1'b1};
      OP_DEC: bin_res = src - {{(N-1){1'b0}}, 1'b1};
      default: ;
    endcase
    zn_val = (op == OP_CMP) ? sum[N-1:0] : bin_res;
    if (op <= OP_DEC) begin
      bin_flags[1] = (zn_val == '0);
      bin_flags[3] = zn_val[N-1];
    end
  end

`ifdef ALU_SEQ_DECIMAL_EN
  localparam int NIBS = N / 4;
  localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  logic [N-1:0]  a_q, m_q, dres_q, dec_word;
  logic          sub_q, carry_q, v_q;
  logic [IW-1:0] nib_idx, idx;
  logic [3:0]    nib_a, nib_m, nib_t;
  logic [4:0]    t5;
  logic          nib_c, nib_sub, nib_cout, last, v_fin;

  // Nibble 0 is adjusted on the live operands at accept; DADJ walks the captured ones.
  always_comb begin
    if (state == S_DADJ) begin
      idx     = nib_idx;
      nib_a   = a_q[{idx, 2'b00} +: 4];
      nib_m   = m_q[{idx, 2'b00} +: 4];
      nib_c   = carry_q;
      nib_sub = sub_q;
      last    = (nib_idx == IW'(NIBS - 1));
      v_fin   = v_q;
    end else begin
      idx     = '0;
      nib_a   = a[3:0];
      nib_m   = mem[3:0];
      nib_c   = flags[0];
      nib_sub = (op == OP_SBC);
      last    = (NIBS == 1);
      v_fin   = v_bin;
    end
    if (nib_sub) begin
      t5       = {1'b0, nib_a} - {1'b0, nib_m} - {4'b0, ~nib_c};
      nib_cout = ~t5[4];
      nib_t    = t5[4] ? t5[3:0] - 4'd6 : t5[3:0];
    end else begin
      t5       = {1'b0, nib_a} + {1'b0, nib_m} + {4'b0, nib_c};
      nib_cout = (t5 > 5'd9);
      nib_t    = nib_cout ? t5[3:0] + 4'd6 : t5[3:0];
    end
    dec_word = (state == S_DADJ) ? dres_q : '0;
    dec_word[{idx, 2'b00} +: 4] = nib_t;
  end

  assign dec_go    = dec & (op == OP_ADC || op == OP_SBC);
  assign dec_done  = ((state == S_DADJ) & last) | (accept & dec_go & last);
  assign dec_res   = dec_word;
  assign dec_flags = {dec_word[N-1], v_fin, dec_word == '0, nib_cout};
  assign acc_state = (dec_go & ~last) ? S_DADJ : S_DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      m_q     <= '0;
      dres_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      v_q     <= 1'b0;
      nib_idx <= '0;
    end else if (accept && dec_go) begin
      a_q     <= a;
      m_q     <= mem;
      sub_q   <= (op == OP_SBC);
      carry_q <= nib_cout;
      v_q     <= v_bin;
      dres_q  <= dec_word;
      nib_idx <= IW'(1);
    end else if (state == S_DADJ) begin
      carry_q <= nib_cout;
      dres_q  <= dec_word;
      nib_idx <= nib_idx + 1'b1;
    end
  end
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign dec_go     = 1'b0;
  assign dec_done   = 1'b0;
  assign dec_res    = '0;
  assign dec_flags  = '0;
  assign acc_state  = S_DONE;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = acc_state;
`ifdef ALU_SEQ_DECIMAL_EN
      S_DADJ: if (dec_done) state_nx = S_DONE;
`endif
      S_DONE: begin
        if (accept)         state_nx = acc_state;
        else if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= state_nx;
      if (dec_done) begin
        result <= dec_res;
        flags  <= dec_flags;
      end else if (accept && !dec_go) begin
        result <= bin_res;
        flags  <= bin_flags;
      end else if (flag_wr && state == S_IDLE) begin
        flags <= flag_din;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random ops against an arithmetic model.
// Decimal scenarios run only when ALU_SEQ_DECIMAL_EN is defined for the build.
module tb_alu_seq;
  localparam int N    = 8;
  localparam int MASK = (1 << N) - 1;
  localparam int HALF = 1 << (N - 1);
`ifdef ALU_SEQ_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [3:0]   op = 4'h0;
  logic [N-1:0] a = '0, mem = '0;
  logic         tgt = 1'b0, dec = 1'b0, flag_wr = 1'b0;
  logic [3:0]   flag_din = 4'h0;
  logic         out_valid, out_ready = 1'b0;
  logic [N-1:0] result;
  logic [3:0]   flags;

  int vectors = 0, miscompares = 0;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a),
    .mem(mem), .tgt(tgt), .dec(dec), .flag_wr(flag_wr), .flag_din(flag_din),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - (1 << N) : x;
  endfunction

  // Reference: {result, N, V, Z, C} from the arithmetic meaning of each op.
  function automatic logic [N+3:0] model(input int o, input int av, input int mv,
                                         input bit t, input bit d, input logic [3:0] fin);
    int s, c, r, zv, full, sr;
    bit nf, vf, zf, cf, upd;
    nf = fin[3]; vf = fin[2]; zf = fin[1]; cf = fin[0];
    c = int'(fin[0]); s = t ? mv : av; r = av; upd = 1'b1;
    case (o)
      0: begin full = av + mv + c; r = full & MASK; cf = (full > MASK);
               sr = sgn(av) + sgn(mv) + c; vf = (sr >= HALF) || (sr < -HALF); end
      1: begin full = av - mv - (1 - c); r = full & MASK; cf = (full >= 0);
               sr = sgn(av) - sgn(mv) - (1 - c); vf = (sr >= HALF) || (sr < -HALF); end
      2: r = av & mv;
      3: r = av | mv;
      4: r = av ^ mv;
      5: begin r = (s * 2) & MASK;     cf = (s >= HALF); end
      6: begin r = s / 2;              cf = (s % 2) == 1; end
      7: begin r = (s * 2 + c) & MASK; cf = (s >= HALF); end
      8: begin r = s / 2 + c * HALF;   cf = (s % 2) == 1; end
      9: cf = (av >= mv);
      10: r = (s + 1) & MASK;
      11: r = (s - 1) & MASK;
      default: upd = 1'b0;
    endcase
    zv = (o == 9) ? ((av - mv) & MASK) : r;
`ifdef ALU_SEQ_DECIMAL_EN
    if (d && (o == 0 || o == 1)) begin
      int cc;
      cc = c; r = 0;
      for (int k = 0; k < N / 4; k++) begin
        int x, y, tt;
        x = (av >> (4 * k)) & 15;
        y = (mv >> (4 * k)) & 15;
        if (o == 0) begin
          tt = x + y + cc;
          if (tt > 9) begin tt += 6; cc = 1; end else cc = 0;
        end else begin
          tt = x - y - (1 - cc);
          if (tt < 0) begin tt -= 6; cc = 0; end else cc = 1;
        end
        r |= (tt & 15) << (4 * k);
      end
      cf = (cc == 1); zv = r;
    end
`endif
    if (upd) begin zf = (zv == 0); nf = (zv >= HALF); end
    return {r[N-1:0], nf, vf, zf, cf};
  endfunction

  // Present one op, wait for acceptance, then for out_valid (both bounded); optionally consume.
  task automatic do_op(input logic [3:0] o, input logic [N-1:0] av, input logic [N-1:0] mv,
                       input logic t, input logic d, input bit consume,
                       output logic [N-1:0] res, output logic [3:0] fl, output int lat);
    int guard;
    op = o; a = av; mem = mv; tgt = t; dec = d; in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = N'($urandom); mem = N'($urandom);
    tgt = 1'($urandom); dec = 1'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
    res = result; fl = flags;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_wr = 1'b1; flag_din = f;
    @(posedge clk); #1 flag_wr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({out_valid, result, flags, in_ready} !== {1'b0, N'(0), 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got ov=%b res=%h fl=%b rdy=%b, want ov=0 res=00 fl=0000 rdy=1",
               out_valid, result, flags, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flag_wr();
    flag_wr = 1'b1; flag_din = 4'b1010; in_valid = 1'b1; op = 4'h0; a = 8'h01; mem = 8'h01;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL flag_wr_blocks_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1 flag_wr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, flags} !== {1'b0, 4'b1010}) begin
      miscompares++; $display("FAIL flag_wr_load: got ov=%b fl=%b want ov=0 fl=1010", out_valid, flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_adc_overflow();
    logic [N-1:0] res; logic [3:0] fl; int lat;
    set_flags(4'b0000);
    do_op(4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'hA0, 4'b1100}) begin
      miscompares++; $display("FAIL adc_overflow: got %h/%b want a0/1100", res, fl);
    end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL adc_latency: got %0d want 1", lat); end
  endtask

  task automatic test_sbc_cmp();
    logic [N-1:0] res; logic [3:0] fl; int lat;
    set_flags(4'b0001);
    do_op(4'h1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'hFF, 4'b1000}) begin
      miscompares++; $display("FAIL sbc_borrow: got %h/%b want ff/1000", res, fl);
    end
    do_op(4'h9, 8'h40, 8'h40, 1'b0, 1'b0, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'h40, 4'b0011}) begin
      miscompares++; $display("FAIL cmp_equal: got %h/%b want 40/0011", res, fl);
    end
  endtask

  task automatic test_shifts();
    logic [N-1:0] res; logic [3:0] fl; int lat;
    set_flags(4'b0001);
    do_op(4'h8, 8'hAA, 8'h01, 1'b1, 1'b0, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'h80, 4'b1001}) begin
      miscompares++; $display("FAIL ror_mem: got %h/%b want 80/1001", res, fl);
    end
    do_op(4'h5, 8'h80, 8'h55, 1'b0, 1'b0, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'h00, 4'b0011}) begin
      miscompares++; $display("FAIL asl_acc: got %h/%b want 00/0011", res, fl);
    end
  endtask

`ifdef ALU_SEQ_DECIMAL_EN
  task automatic test_decimal();
    logic [N-1:0] res; logic [3:0] fl; int lat;
    set_flags(4'b0000);
    do_op(4'h0, 8'h19, 8'h28, 1'b0, 1'b1, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'h47, 4'b0000}) begin
      miscompares++; $display("FAIL dec_adc_19_28: got %h/%b want 47/0000", res, fl);
    end
    vectors++;
    if (lat !== N / 4) begin miscompares++; $display("FAIL dec_latency: got %0d want %0d", lat, N / 4); end
    do_op(4'h0, 8'h99, 8'h01, 1'b0, 1'b1, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl} !== {8'h00, 4'b0011}) begin
      miscompares++; $display("FAIL dec_adc_99_01: got %h/%b want 00/0011", res, fl);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [N-1:0] res; logic [3:0] fl; int lat;
    set_flags(4'b0000);
    do_op(4'h0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, res, fl, lat);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin flag_wr = 1'b1; flag_din = 4'b1111; end
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h46, 4'b0000}) begin
        miscompares++;
        $display("FAIL hold_%0d: got ov=%b rdy=%b res=%h fl=%b want ov=1 rdy=0 res=46 fl=0000",
                 i, out_valid, in_ready, result, flags);
      end
      @(posedge clk); #1 flag_wr = 1'b0;
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 4'h4; a = 8'hFF; mem = 8'h0F; dec = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, result, flags} !== {1'b1, 8'hF0, 4'b1000}) begin
      miscompares++;
      $display("FAIL b2b_result: got ov=%b res=%h fl=%b want ov=1 res=f0 fl=1000", out_valid, result, flags);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] res; logic [3:0] fl; int lat;
    set_flags(4'b1111);
    op = 4'h0; a = 8'h19; mem = 8'h28; tgt = 1'b0; dec = DEC_EN; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    vectors++;
    if ({out_valid, result, flags} !== {1'b0, N'(0), 4'b0000}) begin
      miscompares++;
      $display("FAIL rst_midop: got ov=%b res=%h fl=%b want ov=0 res=00 fl=0000", out_valid, result, flags);
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++; $display("FAIL rst_release: got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    do_op(4'h0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, res, fl, lat);
    vectors++;
    if ({res, fl, lat} !== {8'h03, 4'b0000, 32'd1}) begin
      miscompares++; $display("FAIL rst_after_op: got %h/%b lat %0d want 03/0000 lat 1", res, fl, lat);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] res, av, mv; logic [3:0] fl, o, mflags, f; logic [N+3:0] exp;
    logic t, d; int lat, exp_lat;
    mflags = 4'($urandom);
    set_flags(mflags);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin f = 4'($urandom); set_flags(f); mflags = f; end
      o = 4'($urandom); t = 1'($urandom); d = 1'($urandom);
      av = ($urandom_range(0, 3) == 0) ? N'(($urandom_range(0, 1) == 1) ? MASK : HALF) : N'($urandom);
      mv = ($urandom_range(0, 3) == 0) ? N'(($urandom_range(0, 1) == 1) ? 0 : HALF - 1) : N'($urandom);
      exp = model(int'(o), int'(av), int'(mv), t, d, mflags);
      exp_lat = (DEC_EN && d && o < 4'h2) ? N / 4 : 1;
      do_op(o, av, mv, t, d, 1'b1, res, fl, lat);
      vectors++;
      if ({res, fl} !== exp) begin
        miscompares++;
        $display("FAIL rand_%0d op=%h a=%h m=%h tgt=%b dec=%b: got %h/%b want %h/%b",
                 i, o, av, mv, t, d, res, fl, exp[N+3:4], exp[3:0]);
      end
      vectors++;
      if (lat !== exp_lat) begin
        miscompares++; $display("FAIL rand_lat_%0d op=%h: got %0d want %0d", i, o, lat, exp_lat);
      end
      mflags = exp[3:0];
    end
  endtask

  initial begin
    test_reset();
    test_flag_wr();
    test_adc_overflow();
    test_sbc_cmp();
    test_shifts();
`ifdef ALU_SEQ_DECIMAL_EN
    test_decimal();
`endif
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
